// File: rtl/if_fetch.sv
// if_fetch: RV32I instruction-fetch stage.
// Builds each 32-bit instruction from four byte reads on the memory byte
// port, presents it with its PC to IF/ID, and redirects on decode's
// branch/jump resolution.
// Optional feature macro: ICACHE_EN (32-entry direct-mapped instruction cache).
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [7:0]  mem_byte_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;

  logic        hit_s;
  logic [31:0] hit_data_s;
  logic        byte_ok_s;

`ifdef ICACHE_EN
  logic [31:0] cvalid_q;
  logic [24:0] ctag_q  [32];
  logic [31:0] cdata_q [32];
  logic [4:0]  idx_s;
  logic        fill_s;

  assign idx_s      = pc_q[6:2];
  // A lookup is only meaningful at the start of a live fetch.
  assign hit_s      = req_q && (state_q == S_FETCH) && (cnt_q == 2'd0) &&
                      cvalid_q[idx_s] && (ctag_q[idx_s] == pc_q[31:7]);
  assign hit_data_s = cdata_q[idx_s];
  // Fill on the edge that lands byte 3, unless a redirect discards the word.
  assign fill_s     = (state_q == S_FETCH) && byte_ok_s && (cnt_q == 2'd3) &&
                      !branch_flag_i;
  // On a hit the memory port stays idle.
  assign mem_req_o  = req_q & ~hit_s;

  // Cache valid bits: cleared by reset, set by a fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cvalid_q <= 32'd0;
    end else if (fill_s) begin
      cvalid_q[idx_s] <= 1'b1;
    end
  end

  // Cache tag and data storage, written on fill.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      ctag_q[idx_s]  <= pc_q[31:7];
      cdata_q[idx_s] <= {mem_byte_i, inst_q[23:0]};
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'd0;
  assign mem_req_o  = req_q;
`endif

  // A byte counts only if it answers a request we are actually making.
  assign byte_ok_s = mem_req_o & mem_valid_i;

  // Next-state logic: redirect has priority over fetch progress and consume.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (branch_flag_i) begin
      pc_d    = branch_target_i & 32'hFFFF_FFFC;
      cnt_d   = 2'd0;
      valid_d = 1'b0;
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (hit_s) begin
            inst_d  = hit_data_s;
            cnt_d   = 2'd0;
            valid_d = 1'b1;
            state_d = S_READY;
          end else if (byte_ok_s) begin
            case (cnt_q)
              2'd0:    inst_d[7:0]   = mem_byte_i;
              2'd1:    inst_d[15:8]  = mem_byte_i;
              2'd2:    inst_d[23:16] = mem_byte_i;
              2'd3:    inst_d[31:24] = mem_byte_i;
              default: inst_d        = inst_q;
            endcase
            if (cnt_q == 2'd3) begin
              cnt_d   = 2'd0;
              valid_d = 1'b1;
              state_d = S_READY;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_READY: begin
          if (!stall_i) begin
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
            state_d = S_FETCH;
          end else begin
            pc_d = pc_q;
          end
        end
        default: begin
          state_d = S_FETCH;
          cnt_d   = 2'd0;
          valid_d = 1'b0;
        end
      endcase
    end
    // Bus signals are precomputed from next state so they come from flops.
    req_d  = (state_d == S_FETCH);
    addr_d = pc_d + {30'd0, cnt_d};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= 2'd0;
      pc_q    <= 32'd0;
      inst_q  <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed plus randomized bench for if_fetch with a
// transaction-level reference model and a wait-state memory responder.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [7:0]  mem_byte_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ICACHE_EN
  localparam int LAT_HIT = 1;
  localparam logic REQ_ON_HIT = 1'b0;
  bit          m_cv   [32];
  logic [31:0] m_ctag [32];
`else
  localparam int LAT_HIT = 4;
  localparam logic REQ_ON_HIT = 1'b1;
`endif

  // Reference model: bytes collected so far (4 = instruction presented).
  bit          m_rst;
  logic [31:0] m_pc;
  int          m_k;

  // Memory responder state.
  int          wait_cfg;
  int          rp_waited;
  int          rp_need;
  bit          rp_req;
  bit          rp_done;
  logic [31:0] rp_addr;

  int n;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_valid_i     (mem_valid_i),
    .mem_byte_i      (mem_byte_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_at(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h05;
      32'h2:   return 8'h50;
      32'h3:   return 8'h00;
      default: return (a[7:0] * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_at(a + 32'd3), mem_at(a + 32'd2), mem_at(a + 32'd1), mem_at(a)};
  endfunction

  function automatic bit m_hit();
`ifdef ICACHE_EN
    return !m_rst && (m_k == 0) && m_cv[m_pc[6:2]] && (m_ctag[m_pc[6:2]] == m_pc);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rst = 1'b1;
    m_pc  = 32'd0;
    m_k   = 0;
`ifdef ICACHE_EN
    for (int i = 0; i < 32; i++) m_cv[i] = 1'b0;
`endif
  endtask

  // One clock cycle: respond, check against the model, clock, update model.
  task automatic tick();
    logic        v;
    bit          hit;
    logic        cur_req;
    logic [31:0] cur_addr;
    v = 1'b0;
    if (mem_req_o === 1'b1) begin
      if (!rp_req || rp_done || (mem_addr_o != rp_addr)) begin
        rp_waited = 0;
        rp_need   = (wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 2));
      end
      v = (rp_waited >= rp_need);
    end
    mem_valid_i = v;
    mem_byte_i  = v ? mem_at(mem_addr_o) : 8'($urandom);
    #1;
    hit = m_hit();
    if (m_rst) begin
      check32("rst_pc",    pc_o,                 32'd0);
      check32("rst_inst",  inst_o,               32'd0);
      check32("rst_valid", {31'd0, inst_valid_o}, 32'd0);
      check32("rst_req",   {31'd0, mem_req_o},   32'd0);
      check32("rst_addr",  mem_addr_o,           32'd0);
    end else begin
      check32("pc", pc_o, m_pc);
      if (m_k == 4) begin
        check32("valid_ready", {31'd0, inst_valid_o}, 32'd1);
        check32("req_ready",   {31'd0, mem_req_o},    32'd0);
        check32("inst",        inst_o,                word_at(m_pc));
      end else begin
        check32("valid_fetch", {31'd0, inst_valid_o}, 32'd0);
        check32("req_fetch",   {31'd0, mem_req_o},    {31'd0, !hit});
        if (!hit) check32("addr", mem_addr_o, m_pc + 32'(m_k));
      end
    end
    cur_req  = mem_req_o;
    cur_addr = mem_addr_o;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (branch_flag_i) begin
        m_pc = branch_target_i & 32'hFFFF_FFFC;
        m_k  = 0;
      end else if (m_k == 4) begin
        if (!stall_i) begin
          m_pc = m_pc + 32'd4;
          m_k  = 0;
        end
      end else if (hit) begin
        m_k = 4;
      end else if (cur_req && v) begin
`ifdef ICACHE_EN
        if (m_k == 3) begin
          m_cv[m_pc[6:2]]   = 1'b1;
          m_ctag[m_pc[6:2]] = m_pc;
        end
`endif
        m_k = m_k + 1;
      end
      m_rst = 1'b0;
    end
    rp_req  = cur_req;
    rp_addr = cur_addr;
    rp_done = v || branch_flag_i || !rst;
    if (!v) rp_waited++;
    @(negedge clk);
  endtask

  task automatic run_to_valid(input int max, output int cycles);
    cycles = 0;
    while (inst_valid_o !== 1'b1 && cycles < max) begin
      tick();
      cycles++;
    end
    check32("valid_timeout", {31'd0, inst_valid_o}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    branch_flag_i   = 1'b1;
    branch_target_i = tgt;
    tick();
    branch_flag_i   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'd0;
    mem_valid_i = 1'b0; mem_byte_i = 8'd0; wait_cfg = 0;
    rp_waited = 0; rp_need = 0; rp_req = 1'b0; rp_done = 1'b1; rp_addr = 32'd0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset held for 3 cycles, then release and first zero-wait fetch.
    repeat (3) tick();
    rst = 1'b1;
    tick();
    run_to_valid(20, n);
    check32("first_latency", n, 32'd4);
    check32("first_inst", inst_o, 32'h0050_0513);
    check32("first_pc", pc_o, 32'd0);
    tick();
    check32("next_addr", mem_addr_o, 32'h4);

    // Two wait cycles per byte.
    wait_cfg = 2;
    run_to_valid(40, n);
    check32("wait_latency", n, 32'd12);

    // Stall in READY for 5 cycles, then consume.
    stall_i = 1'b1;
    repeat (5) tick();
    stall_i = 1'b0;
    tick();
    check32("pc_after_stall", pc_o, 32'h8);

    // Redirect after bytes 0 and 1; byte 2 in the branch cycle is dropped.
    wait_cfg = 0;
    tick();
    tick();
    redirect(32'h0000_0103);
    check32("redir_addr", mem_addr_o, 32'h100);
    check32("redir_req", {31'd0, mem_req_o}, 32'd1);
    run_to_valid(20, n);
    check32("redir_latency", n, 32'd4);
    check32("redir_inst", inst_o, word_at(32'h100));

    // Branch wins over consume in READY.
    redirect(32'h20);
    run_to_valid(20, n);
    check32("pc_0x20", pc_o, 32'h20);
    redirect(32'h40);
    check32("branch_vs_consume", pc_o, 32'h40);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFD);
    check32("wrap_pc", pc_o, 32'hFFFF_FFFC);
    run_to_valid(20, n);
    tick();
    check32("wrap_next", pc_o, 32'h0);

    // Loop 0x0 -> 0x8 -> back to 0x0, then reset and revisit.
    redirect(32'h0);
    run_to_valid(20, n);
    tick();
    run_to_valid(20, n);
    tick();
    run_to_valid(20, n);
    redirect(32'h0);
    check32("loop_req", {31'd0, mem_req_o}, {31'd0, REQ_ON_HIT});
    run_to_valid(20, n);
    check32("loop_latency", n, 32'(LAT_HIT));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    run_to_valid(20, n);
    check32("after_reset_latency", n, 32'd4);

    // Randomized traffic: wait states, stalls, redirects.
    wait_cfg = -1;
    for (int i = 0; i < 600; i++) begin
      int r;
      stall_i       = ($urandom_range(0, 9) < 3);
      branch_flag_i = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 3));
      if (r == 0)      branch_target_i = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else if (r == 1) branch_target_i = $urandom_range(0, 255);
      else             branch_target_i = $urandom;
      tick();
    end
    branch_flag_i = 1'b0;
    stall_i       = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
